simd_warp_core: RTL and testbench
=================================

// Module: simd_warp_core
// PURPOSE
//  Single-warp SIMD execution core: accepts one kernel descriptor (warp id, active thread count,
//  start PC), loads per-thread register files, fetches RV32I-subset instructions from an external
//  IMEM and executes each on all active threads in lockstep. Reports completion with warp id and
//  per-thread result (x10). Sits under the warp scheduler; IMEM and init data are external.
// PARAMETERS
//  THREAD_COUNT  4   lanes per warp (from Structs_and_Params.svh)
// PORTS
//  clk                    in   1                  clock, all state on rising edge
//  rst                    in   1                  synchronous, active-high reset
//  kernel_in              in   kernel_t           {warp_id[3:0], thread_count, start_pc[31:0]}; warp_id 4'hF = no kernel
//  instruction_from_imem  in   32                 instruction at address instruction_fetch, valid same cycle
//  init_reg_data          in   32 x [THREAD_COUNT][32]  initial register values, indexed [thread][reg]
//  is_finished_out        out  1                  one-cycle pulse: warp completed
//  result_out             out  32 x [THREAD_COUNT] per-thread x10, valid/held from finish pulse
//  instruction_fetch      out  32                 IMEM fetch address (PC)
//  init_reg_data_fetch    out  32                 init-data request: {28'b0, warp_id} in LOAD, else 32'hFFFF_FFFF
//  finished_warp_id       out  4                  warp id of last completed kernel; 4'hF when none
// BEHAVIOUR
//  Reset (rst=1 at edge): state IDLE, PC=0, all regs=0, is_finished_out=0, result_out all 0,
//   instruction_fetch=0, init_reg_data_fetch=32'hFFFF_FFFF, finished_warp_id=4'hF. Reset wins mid-op.
//  FSM: IDLE -> LOAD -> FETCH -> EXEC -> FETCH ... -> DONE -> IDLE.
//  IDLE: accept when kernel_in.warp_id!=4'hF, thread_count!=0, and warp_id differs from last accepted
//   id or 4'hF was seen since; latch warp_id, start_pc, active = min(thread_count, THREAD_COUNT).
//  LOAD (1 cycle): regfile[t][r] <= init_reg_data[t][r] for all t, r=1..31; x0 stays 0.
//  FETCH: instruction_fetch = PC; IR <= instruction_from_imem at end of cycle.
//  EXEC: decode IR, write rd in every lane t<active (rd!=0); lanes t>=active never written; PC+=4.
//   R-type 0110011: ADD, SUB (f7=0100000), AND, OR, XOR, SLL, SRL, SLT, SLTU (shift amount rs2[4:0]).
//   I-type 0010011: ADDI, ANDI, ORI, XORI, SLTI (imm sign-extended 12b). LUI 0110111.
//   IR==32'h0000_0000 or ECALL (32'h0000_0073) -> DONE, no write. Other opcodes: NOP, PC+=4.
//   Arithmetic 32-bit wrap-around, no exceptions. PC wraps at 2^32.
//  DONE (1 cycle): is_finished_out=1, finished_warp_id=latched id, result_out[t]=x10 of lane t
//   (0 for inactive lanes); next IDLE. result_out/finished_warp_id hold until next DONE or reset.
//  Kernel changes outside IDLE are ignored. No branches/loads/stores in this block.
// TESTING
//  Reset 2 cycles, kernel warp_id=4'hF -> stays IDLE, finished_warp_id=4'hF, is_finished_out=0.
//  Kernel {1,4,32'h1234_5678}, IMEM all 0 -> instruction_fetch=32'h1234_5678 in FETCH, finish pulse
//   4 cycles after accept, finished_warp_id=1, result_out = init x10 per lane; held kernel not re-run.
//  init x5=t+1, prog ADDI x10,x5,100; ECALL -> result_out={101,102,103,104}.
//  thread_count=2, same prog -> result_out={101,102,0,0}; lanes 2,3 unwritten.
//  SUB x10,x0,x5 with x5=1 -> 32'hFFFF_FFFF; ADDI x0,x0,5 -> x0 remains 0.
//  Assert rst during EXEC -> next cycle IDLE, all outputs at reset values, no finish pulse.

Source files
------------

// File: rtl/simd_warp_core.sv
// simd_warp_core: single-warp SIMD core. Accepts one kernel descriptor,
// loads the per-lane register files, then fetches RV32I-subset instructions
// and executes each one on all active lanes in lockstep until ECALL or a
// zero word. It then reports the warp id and every lane's x10.
module simd_warp_core #(
  parameter int THREAD_COUNT = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [43:0]                           kernel_in,
  input  logic [31:0]                           instruction_from_imem,
  input  logic [THREAD_COUNT-1:0][31:0][31:0]   init_reg_data,
  output logic                                  is_finished_out,
  output logic [THREAD_COUNT-1:0][31:0]         result_out,
  output logic [31:0]                           instruction_fetch,
  output logic [31:0]                           init_reg_data_fetch,
  output logic [3:0]                            finished_warp_id
);

  // kernel_in layout: {warp_id[3:0], thread_count[7:0], start_pc[31:0]}
  localparam int TC_W = 8;
  localparam logic [3:0] NO_WARP = 4'hF;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_EXEC,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [31:0]                          pc_q;
  logic [31:0]                          ir_q;
  logic [THREAD_COUNT-1:0][31:0][31:0]  rf_q;
  logic [3:0]                           warp_q;
  logic [TC_W-1:0]                      active_q;
  logic [3:0]                           last_id_q;
  logic                                 rearm_q;
  logic                                 fin_q;
  logic [THREAD_COUNT-1:0][31:0]        res_q;
  logic [3:0]                           fid_q;

  logic [3:0]      k_id;
  logic [TC_W-1:0] k_tc;
  logic [31:0]     k_pc;
  logic            accept;

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic        exec_done;
  logic        op_wr;
  logic [31:0] a_v;
  logic [31:0] b_v;
  logic [THREAD_COUNT-1:0][31:0] lane_res;
  logic        unused_x0;

  assign k_id = kernel_in[43:40];
  assign k_tc = kernel_in[39:32];
  assign k_pc = kernel_in[31:0];

  // A repeated warp id is only accepted again once "no kernel" has been seen.
  assign accept = (state_q == S_IDLE) && (k_id != NO_WARP) && (k_tc != '0) &&
                  ((k_id != last_id_q) || rearm_q);

  assign opcode    = ir_q[6:0];
  assign rd        = ir_q[11:7];
  assign f3        = ir_q[14:12];
  assign rs1       = ir_q[19:15];
  assign rs2       = ir_q[24:20];
  assign f7        = ir_q[31:25];
  assign imm_i     = {{20{ir_q[31]}}, ir_q[31:20]};
  assign exec_done = (ir_q == 32'h0000_0000) || (ir_q == 32'h0000_0073);

  // x0 of the init data is never loaded; fold it away explicitly.
  always_comb begin
    unused_x0 = 1'b0;
    for (int unsigned t = 0; t < THREAD_COUNT; t++) begin
      unused_x0 = unused_x0 ^ (^init_reg_data[t][0]);
    end
  end

  // Decide whether the current instruction writes rd.
  always_comb begin
    op_wr = 1'b0;
    case (opcode)
      OP_R:    op_wr = (f7 == 7'b0000000) || ((f7 == 7'b0100000) && (f3 == 3'b000));
      OP_I:    op_wr = (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b100) ||
                       (f3 == 3'b110) || (f3 == 3'b111);
      OP_LUI:  op_wr = 1'b1;
      default: op_wr = 1'b0;
    endcase
  end

  // Per-lane ALU result for the current instruction.
  always_comb begin
    a_v      = '0;
    b_v      = '0;
    lane_res = '0;
    for (int unsigned t = 0; t < THREAD_COUNT; t++) begin
      a_v = rf_q[t][rs1];
      b_v = rf_q[t][rs2];
      case (opcode)
        OP_R: begin
          case (f3)
            3'b000:  lane_res[t] = f7[5] ? (a_v - b_v) : (a_v + b_v);
            3'b001:  lane_res[t] = a_v << b_v[4:0];
            3'b010:  lane_res[t] = {31'b0, $signed(a_v) < $signed(b_v)};
            3'b011:  lane_res[t] = {31'b0, a_v < b_v};
            3'b100:  lane_res[t] = a_v ^ b_v;
            3'b101:  lane_res[t] = a_v >> b_v[4:0];
            3'b110:  lane_res[t] = a_v | b_v;
            default: lane_res[t] = a_v & b_v;
          endcase
        end
        OP_I: begin
          case (f3)
            3'b000:  lane_res[t] = a_v + imm_i;
            3'b010:  lane_res[t] = {31'b0, $signed(a_v) < $signed(imm_i)};
            3'b100:  lane_res[t] = a_v ^ imm_i;
            3'b110:  lane_res[t] = a_v | imm_i;
            3'b111:  lane_res[t] = a_v & imm_i;
            default: lane_res[t] = '0;
          endcase
        end
        OP_LUI:  lane_res[t] = {ir_q[31:12], 12'b0};
        default: lane_res[t] = '0;
      endcase
    end
  end

  // Next-state and init-data request.
  always_comb begin
    state_d             = state_q;
    init_reg_data_fetch = 32'hFFFF_FFFF;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_LOAD;
      S_LOAD: begin
        state_d             = S_FETCH;
        init_reg_data_fetch = {28'b0, warp_q};
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC:  state_d = exec_done ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath: kernel latch, register files, PC/IR and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= '0;
      ir_q      <= '0;
      rf_q      <= '0;
      warp_q    <= NO_WARP;
      active_q  <= '0;
      last_id_q <= NO_WARP;
      rearm_q   <= 1'b1;
      fin_q     <= 1'b0;
      res_q     <= '0;
      fid_q     <= NO_WARP;
    end else begin
      fin_q <= 1'b0;
      if (k_id == NO_WARP) rearm_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            warp_q    <= k_id;
            pc_q      <= k_pc;
            active_q  <= (k_tc > TC_W'(THREAD_COUNT)) ? TC_W'(THREAD_COUNT) : k_tc;
            last_id_q <= k_id;
            rearm_q   <= 1'b0;
          end
        end
        S_LOAD: begin
          for (int unsigned t = 0; t < THREAD_COUNT; t++) begin
            rf_q[t][0] <= '0;
            for (int unsigned r = 1; r < 32; r++) begin
              rf_q[t][r] <= init_reg_data[t][r];
            end
          end
        end
        S_FETCH: ir_q <= instruction_from_imem;
        S_EXEC: begin
          if (!exec_done) begin
            pc_q <= pc_q + 32'd4;
            if (op_wr && (rd != 5'd0)) begin
              for (int unsigned t = 0; t < THREAD_COUNT; t++) begin
                if (TC_W'(t) < active_q) rf_q[t][rd] <= lane_res[t];
              end
            end
          end
        end
        S_DONE: begin
          fin_q <= 1'b1;
          fid_q <= warp_q;
          for (int unsigned t = 0; t < THREAD_COUNT; t++) begin
            res_q[t] <= (TC_W'(t) < active_q) ? rf_q[t][10] : '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign is_finished_out   = fin_q;
  assign result_out        = res_q;
  assign instruction_fetch = pc_q;
  assign finished_warp_id  = fid_q;

endmodule

// File: tb/tb_simd_warp_core.sv
// Bench for simd_warp_core: directed kernels plus randomized programs checked
// against an instruction-level reference model of the warp.
module tb_simd_warp_core;

  localparam int TC = 4;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [43:0]                 kernel_in;
  logic [31:0]                 instruction_from_imem;
  logic [TC-1:0][31:0][31:0]   init;
  logic                        is_finished_out;
  logic [TC-1:0][31:0]         result_out;
  logic [31:0]                 instruction_fetch;
  logic [31:0]                 init_reg_data_fetch;
  logic [3:0]                  finished_warp_id;

  simd_warp_core #(.THREAD_COUNT(TC)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .kernel_in             (kernel_in),
    .instruction_from_imem (instruction_from_imem),
    .init_reg_data         (init),
    .is_finished_out       (is_finished_out),
    .result_out            (result_out),
    .instruction_fetch     (instruction_fetch),
    .init_reg_data_fetch   (init_reg_data_fetch),
    .finished_warp_id      (finished_warp_id)
  );

  always #5 clk = ~clk;

  typedef enum int {
    K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_SLL, K_SRL, K_SLT, K_SLTU,
    K_ADDI, K_ANDI, K_ORI, K_XORI, K_SLTI, K_LUI, K_NOP
  } kind_t;

  kind_t       pk   [32];
  logic [4:0]  prd  [32];
  logic [4:0]  prs1 [32];
  logic [4:0]  prs2 [32];
  logic [31:0] pimm [32];
  int          plen;

  logic [31:0] pw [32];
  logic [31:0] base_pc;
  logic [31:0] off;

  logic [31:0] mr  [TC][32];
  logic [31:0] exp_res [TC];

  int n_checks = 0;
  int n_pass   = 0;

  // IMEM: program words placed at base_pc, zeros everywhere else.
  always_comb begin
    off = instruction_fetch - base_pc;
    instruction_from_imem = '0;
    if (off[31:7] == '0 && off[1:0] == 2'b00) instruction_from_imem = pw[off[6:2]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] enc(kind_t k, logic [4:0] rd, logic [4:0] rs1,
                                      logic [4:0] rs2, logic [31:0] imm);
    case (k)
      K_ADD:   return {7'h00, rs2, rs1, 3'd0, rd, 7'h33};
      K_SUB:   return {7'h20, rs2, rs1, 3'd0, rd, 7'h33};
      K_SLL:   return {7'h00, rs2, rs1, 3'd1, rd, 7'h33};
      K_SLT:   return {7'h00, rs2, rs1, 3'd2, rd, 7'h33};
      K_SLTU:  return {7'h00, rs2, rs1, 3'd3, rd, 7'h33};
      K_XOR:   return {7'h00, rs2, rs1, 3'd4, rd, 7'h33};
      K_SRL:   return {7'h00, rs2, rs1, 3'd5, rd, 7'h33};
      K_OR:    return {7'h00, rs2, rs1, 3'd6, rd, 7'h33};
      K_AND:   return {7'h00, rs2, rs1, 3'd7, rd, 7'h33};
      K_ADDI:  return {imm[11:0], rs1, 3'd0, rd, 7'h13};
      K_SLTI:  return {imm[11:0], rs1, 3'd2, rd, 7'h13};
      K_XORI:  return {imm[11:0], rs1, 3'd4, rd, 7'h13};
      K_ORI:   return {imm[11:0], rs1, 3'd6, rd, 7'h13};
      K_ANDI:  return {imm[11:0], rs1, 3'd7, rd, 7'h13};
      K_LUI:   return {imm[19:0], rd, 7'h37};
      default: return {imm[24:0], 7'h23};  // store opcode: unsupported, acts as NOP
    endcase
  endfunction

  function automatic logic [31:0] ref_op(kind_t k, logic [31:0] a, logic [31:0] b,
                                         logic [31:0] imm);
    case (k)
      K_ADD:   return a + b;
      K_SUB:   return a - b;
      K_AND:   return a & b;
      K_OR:    return a | b;
      K_XOR:   return a ^ b;
      K_SLL:   return a << b[4:0];
      K_SRL:   return a >> b[4:0];
      K_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      K_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      K_ADDI:  return a + imm;
      K_ANDI:  return a & imm;
      K_ORI:   return a | imm;
      K_XORI:  return a ^ imm;
      K_SLTI:  return ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
      K_LUI:   return imm << 12;
      default: return '0;
    endcase
  endfunction

  task automatic add_instr(input kind_t k, input int rd, input int rs1, input int rs2,
                           input logic [31:0] imm);
    pk[plen] = k; prd[plen] = 5'(rd); prs1[plen] = 5'(rs1); prs2[plen] = 5'(rs2);
    pimm[plen] = imm;
    plen++;
  endtask

  task automatic model_run(input int tc);
    int active;
    logic [31:0] v;
    active = (tc > TC) ? TC : tc;
    for (int t = 0; t < TC; t++)
      for (int r = 0; r < 32; r++) mr[t][r] = (r == 0) ? 32'd0 : init[t][r];
    for (int i = 0; i < plen; i++) begin
      for (int t = 0; t < active; t++) begin
        v = ref_op(pk[i], mr[t][prs1[i]], mr[t][prs2[i]], pimm[i]);
        if (pk[i] != K_NOP && prd[i] != 5'd0) mr[t][prd[i]] = v;
      end
    end
    for (int t = 0; t < TC; t++) exp_res[t] = (t < active) ? mr[t][10] : 32'd0;
  endtask

  // Runs the loaded program as one kernel; starts and ends at a negedge with
  // the core idle. term is the word placed after the program (ECALL or 0).
  task automatic run_kernel(input string tag, input logic [3:0] id, input int tc,
                            input logic [31:0] pc, input logic [31:0] term);
    int k;
    int lat;
    bit seen;
    for (int i = 0; i < 32; i++) pw[i] = '0;
    for (int i = 0; i < plen; i++) pw[i] = enc(pk[i], prd[i], prs1[i], prs2[i], pimm[i]);
    pw[plen] = term;
    base_pc = pc;
    model_run(tc);
    lat = 2 * plen + 5;
    kernel_in = {id, 8'(tc), pc};
    seen = 1'b0;
    k = 0;
    while (!seen && k < lat + 20) begin
      @(posedge clk); @(negedge clk);
      k++;
      if (k == 1) check_eq({tag, "_initfetch"}, init_reg_data_fetch, {28'b0, id});
      if (k == 2) check_eq({tag, "_ifetch"}, instruction_fetch, pc);
      if (is_finished_out) seen = 1'b1;
    end
    check_eq({tag, "_latency"}, 32'(k), 32'(lat));
    check_eq({tag, "_warpid"}, {28'b0, finished_warp_id}, {28'b0, id});
    for (int t = 0; t < TC; t++)
      check_eq($sformatf("%s_res%0d", tag, t), result_out[t], exp_res[t]);
    @(posedge clk); @(negedge clk);
    check_eq({tag, "_pulse1"}, {31'b0, is_finished_out}, 32'd0);
  endtask

  task automatic rand_init();
    for (int t = 0; t < TC; t++)
      for (int r = 0; r < 32; r++) init[t][r] = $urandom;
  endtask

  task automatic idle_cycle();
    kernel_in = {4'hF, 8'd0, 32'd0};
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    int pulses;
    logic [3:0] last_id;
    logic [3:0] id;
    logic [11:0] i12;
    kind_t kk;
    int rdv;

    rst = 1'b1;
    kernel_in = {4'hF, 8'd0, 32'd0};
    base_pc = '0;
    plen = 0;
    for (int i = 0; i < 32; i++) pw[i] = '0;
    rand_init();

    // Reset, then idle with no kernel.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_fin", {31'b0, is_finished_out}, 32'd0);
    check_eq("rst_fid", {28'b0, finished_warp_id}, 32'hF);
    check_eq("rst_ifetch", instruction_fetch, 32'd0);
    check_eq("rst_initfetch", init_reg_data_fetch, 32'hFFFF_FFFF);
    check_eq("rst_res0", result_out[0], 32'd0);
    pulses = 0;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (is_finished_out) pulses++;
    end
    check_eq("idle_pulses", 32'(pulses), 32'd0);
    check_eq("idle_fid", {28'b0, finished_warp_id}, 32'hF);
    check_eq("idle_ifetch", instruction_fetch, 32'd0);

    // Empty program (IMEM all zero): result is the loaded x10.
    plen = 0;
    run_kernel("empty", 4'd1, 4, 32'h1234_5678, 32'd0);
    for (int t = 0; t < TC; t++)
      check_eq($sformatf("empty_x10_%0d", t), result_out[t], init[t][10]);

    // Kernel held with the same id must not run again.
    pulses = 0;
    repeat (15) begin
      @(posedge clk); @(negedge clk);
      if (is_finished_out) pulses++;
    end
    check_eq("held_pulses", 32'(pulses), 32'd0);

    // ADDI x10,x5,100 ; ECALL with x5 = t+1.
    for (int t = 0; t < TC; t++) init[t][5] = 32'(t + 1);
    plen = 0;
    add_instr(K_ADDI, 10, 5, 0, 32'd100);
    run_kernel("addi4", 4'd2, 4, 32'h0000_0400, 32'h73);
    for (int t = 0; t < TC; t++)
      check_eq($sformatf("addi4_const%0d", t), result_out[t], 32'(101 + t));

    run_kernel("addi2", 4'd3, 2, 32'h0000_0800, 32'h73);
    check_eq("addi2_l0", result_out[0], 32'd101);
    check_eq("addi2_l1", result_out[1], 32'd102);
    check_eq("addi2_l2", result_out[2], 32'd0);
    check_eq("addi2_l3", result_out[3], 32'd0);

    // SUB x10,x0,x5 with x5 = 1, nonzero init in x0.
    for (int t = 0; t < TC; t++) begin init[t][5] = 32'd1; init[t][0] = 32'h5555_AAAA; end
    plen = 0;
    add_instr(K_SUB, 10, 0, 5, 32'd0);
    run_kernel("sub", 4'd4, 4, 32'h0000_1000, 32'h73);
    check_eq("sub_const", result_out[3], 32'hFFFF_FFFF);

    // ADDI x0,x0,5 ; ADDI x10,x0,7 -> x0 still reads as zero.
    plen = 0;
    add_instr(K_ADDI, 0, 0, 0, 32'd5);
    add_instr(K_ADDI, 10, 0, 0, 32'd7);
    run_kernel("x0", 4'd6, 4, 32'h0000_2000, 32'h73);
    check_eq("x0_const", result_out[0], 32'd7);

    // Reset while executing.
    plen = 0;
    for (int i = 0; i < 6; i++) add_instr(K_ADDI, 10, 10, 0, 32'd1);
    for (int i = 0; i < 32; i++) pw[i] = '0;
    for (int i = 0; i < plen; i++) pw[i] = enc(pk[i], prd[i], prs1[i], prs2[i], pimm[i]);
    pw[plen] = 32'h73;
    base_pc = 32'h0000_0100;
    kernel_in = {4'd5, 8'd4, 32'h0000_0100};
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    kernel_in = {4'hF, 8'd0, 32'd0};
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check_eq("mrst_fin", {31'b0, is_finished_out}, 32'd0);
    check_eq("mrst_fid", {28'b0, finished_warp_id}, 32'hF);
    check_eq("mrst_res0", result_out[0], 32'd0);
    check_eq("mrst_ifetch", instruction_fetch, 32'd0);
    check_eq("mrst_initfetch", init_reg_data_fetch, 32'hFFFF_FFFF);
    pulses = 0;
    repeat (20) begin
      @(posedge clk); @(negedge clk);
      if (is_finished_out) pulses++;
    end
    check_eq("mrst_pulses", 32'(pulses), 32'd0);

    // Randomized kernels against the model.
    last_id = 4'hF;
    for (int it = 0; it < 20; it++) begin
      rand_init();
      plen = 0;
      for (int i = 0; i < $urandom_range(1, 8); i++) begin
        kk  = kind_t'($urandom_range(0, 15));
        rdv = ($urandom_range(0, 2) == 0) ? 10 : int'($urandom_range(0, 31));
        i12 = 12'($urandom);
        if (kk == K_LUI) add_instr(kk, rdv, 0, 0, {12'b0, 20'($urandom)});
        else add_instr(kk, rdv, $urandom_range(0, 31), $urandom_range(0, 31),
                       {{20{i12[11]}}, i12});
      end
      if (last_id == 4'hF || $urandom_range(0, 1) == 1) begin
        idle_cycle();
        id = 4'($urandom_range(0, 14));
      end else begin
        id = 4'((int'(last_id) + int'($urandom_range(1, 14))) % 15);
      end
      run_kernel($sformatf("rnd%0d", it), id, $urandom_range(1, 6),
                 (it == 7) ? 32'hFFFF_FFF4 : {$urandom_range(0, 1023), 2'b00},
                 32'h73);
      last_id = id;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
